mc_sequencer: RTL and testbench
===============================

# mc_sequencer

Program sequencer for the 1-bit ICU datapath. It holds the program counter and fetches instruction words from an asynchronous-read program ROM. It issues the 4-bit opcode and I/O address each cycle and reacts to the ICU's JMP/RTN/NOPO/NOPF flags: jumps, subroutine call/return via a return-address stack, program wrap and halt. It also tracks ICU skip cycles so that flags from skipped instructions are never acted on.

## Interface
- ADDR_W, 8: program-counter and I/O-address width.
- STACK_DEPTH, 4: return-stack entries (≥1).
- clk  in  1  clock; ICU latches `instruction` on negedge, sequencer state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  start/resume pulse, sampled at posedge.
- prog_addr  out  ADDR_W  ROM address, always equals PC.
- prog_data  in  4+ADDR_W  ROM word: [ADDR_W+3:ADDR_W] opcode, [ADDR_W-1:0] address field.
- instruction  out  4  opcode to ICU.
- io_addr  out  ADDR_W  address field, used by the I/O mux and as jump target.
- jmp, rtn, flag_o, flag_f  in  1 each  ICU decode flags.
- rr  in  1  ICU result register.
- running  out  1  state == RUN.
- halted  out  1  state == HALT.
- stack_err  out  1  sticky over/underflow flag.

## Operation
- Opcodes: NOPO=0, LD=1, LDC=2, AND=3, ANDC=4, OR=5, ORC=6, XNOR=7, STO=8, STOC=9, IEN=A, OEN=B, JMP=C, RTN=D, SKZ=E, NOPF=F.
- States:
  - IDLE (reset): instruction=NOPO, io_addr=0, PC=0. run → RUN.
  - RUN: instruction/io_addr combinationally from prog_data.
  - HALT: instruction=NOPO, PC frozen. run → RUN, resuming at the held PC.
- Flags are acted on only in RUN with skip_q=0. Priority at posedge:
  1. flag_f: PC←PC+1, go to HALT.
  2. jmp: push PC (the JMP's own address) and load PC←io_addr.
  3. rtn: pop into PC.
  4. flag_o: PC←0.
  5. Otherwise: PC←PC+1, wrapping at 2^ADDR_W to 0.
- skip_q is set at the posedge when RUN, skip_q=0, and either rtn, or opcode==SKZ with rr==0. It clears at the next posedge.
- While skip_q=1, the instruction is still issued and PC←PC+1, but all flags are ignored. This mirrors the ICU skipping that instruction.
- Return: the pop reloads the JMP address. The ICU skips the re-fetched JMP (post-RTN skip), so execution continues at JMP+1.
- Stack:
  - Push when full: push dropped, stack_err←1, jump still taken.
  - Pop when empty: PC←0, stack_err←1.
  - stack_err clears only on reset.
- Reset mid-operation: state IDLE, PC=0, sp=0, skip_q=0, stack_err=0. All outputs at reset values immediately (asynchronous).

## Timing
- Fetch-issue latency 0: prog_addr=PC and instruction valid within the same cycle.
- Flags for the instruction issued in cycle n are sampled at the posedge ending cycle n. No bubble cycles on JMP/RTN.
- run is ignored in RUN.
- run with simultaneous flag_f: flag_f wins, and run is needed again later.
- Reset values: instruction=0, io_addr=0, prog_addr=0, running=0, halted=0, stack_err=0.

## Configuration
- MC_SEQ_CALL_STACK_EN defined: return stack as specified above.
- Not defined:
  - jmp is a plain jump with no push.
  - rtn loads PC←0.
  - stack_err is tied to 0.
  - No stack storage is instantiated.
  - skip_q behaviour is unchanged.

## Test plan
- Reset then run, ROM 0..3 = LD, AND, STO, NOPO → addresses 0,1,2,3 issued, then PC=0 after NOPO; running=1.
- JMP 0x10 at addr 5; RTN at 0x10 → PC 5→0x10→5 (JMP re-issued, flags ignored)→6; no second push.
- SKZ with rr=0 at addr 2, JMP at 3 → JMP issued but ignored, PC=4. With rr=1 → PC=JMP target.
- NOPF at addr 7 → halted=1, instruction=NOPO for 5 cycles, PC=8 held. run → resumes at 8.
- STACK_DEPTH=2, three nested JMPs → third pushes nothing and stack_err=1. RTN on empty stack → PC=0.
- rst_n low mid-run at PC=0x22 with sp=1 → outputs zero asynchronously; after release state IDLE, PC=0.

Source files
------------

// File: rtl/mc_sequencer.sv
// mc_sequencer: program sequencer for the 1-bit ICU (PC, ROM fetch, jump/call/return, halt).
// Define MC_SEQ_CALL_STACK_EN to build the return-address stack; otherwise RTN returns to address 0.
module mc_sequencer #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic [ADDR_W-1:0] prog_addr,
  input  logic [ADDR_W+3:0] prog_data,
  output logic [3:0]        instruction,
  output logic [ADDR_W-1:0] io_addr,
  input  logic              jmp,
  input  logic              rtn,
  input  logic              flag_o,
  input  logic              flag_f,
  input  logic              rr,
  output logic              running,
  output logic              halted,
  output logic              stack_err
);

  localparam int unsigned OP_W   = 4;
  localparam logic [OP_W-1:0] OP_NOPO = 4'h0;
  localparam logic [OP_W-1:0] OP_SKZ  = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  if (STACK_DEPTH < 1) begin : g_depth_chk
    $error("mc_sequencer: STACK_DEPTH must be at least 1");
  end

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              skip_q, skip_d;
  logic [OP_W-1:0]   opcode_c;
  logic [ADDR_W-1:0] field_c;
  logic [ADDR_W-1:0] pop_addr_c;
  logic              act_c;

  assign opcode_c = prog_data[ADDR_W+OP_W-1:ADDR_W];
  assign field_c  = prog_data[ADDR_W-1:0];
  // Flags only count for an issued instruction that the ICU is not skipping
  assign act_c    = (state_q == ST_RUN) && !skip_q;

  assign prog_addr   = pc_q;
  assign running     = (state_q == ST_RUN);
  assign halted      = (state_q == ST_HALT);
  assign instruction = running ? opcode_c : OP_NOPO;
  assign io_addr     = running ? field_c : '0;

  // Next PC / state / skip selection
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    skip_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (run) state_d = ST_RUN;
      end
      ST_RUN: begin
        pc_d = pc_q + ADDR_W'(1);
        if (act_c) begin
          skip_d = rtn || ((opcode_c == OP_SKZ) && !rr);
          if (flag_f)      state_d = ST_HALT;
          else if (jmp)    pc_d    = field_c;
          else if (rtn)    pc_d    = pop_addr_c;
          else if (flag_o) pc_d    = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      skip_q  <= skip_d;
    end
  end

`ifdef MC_SEQ_CALL_STACK_EN
  localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] stack_q [2**IDX_W];
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              err_q, err_d;
  logic              push_c, pop_c, full_c, empty_c;

  assign push_c     = act_c && !flag_f && jmp;
  assign pop_c      = act_c && !flag_f && !jmp && rtn;
  assign full_c     = (sp_q == SP_W'(STACK_DEPTH));
  assign empty_c    = (sp_q == '0);
  // Underflow returns to address 0
  assign pop_addr_c = empty_c ? '0 : stack_q[IDX_W'(sp_q - SP_W'(1))];

  always_comb begin
    sp_d  = sp_q;
    err_d = err_q;
    if (push_c) begin
      if (full_c) err_d = 1'b1;
      else        sp_d  = sp_q + SP_W'(1);
    end else if (pop_c) begin
      if (empty_c) err_d = 1'b1;
      else         sp_d  = sp_q - SP_W'(1);
    end
  end

  // Push stores the JMP's own address; a push on a full stack is dropped
  always_ff @(posedge clk) begin
    if (push_c && !full_c) stack_q[IDX_W'(sp_q)] <= pc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  assign stack_err = err_q;
`else
  assign pop_addr_c = '0;
  assign stack_err  = 1'b0;
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed bench for mc_sequencer: ROM model plus ICU flag decode, hand-computed PC trace per scenario.
module tb_mc_sequencer;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned DW     = ADDR_W + 4;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              run   = 1'b0;
  logic              rr    = 1'b0;
  logic [ADDR_W-1:0] prog_addr;
  logic [ADDR_W-1:0] io_addr;
  logic [DW-1:0]     prog_data;
  logic [3:0]        instruction;
  logic              jmp, rtn, flag_o, flag_f;
  logic              running, halted, stack_err;

  logic [DW-1:0] rom [2**ADDR_W];
  int n_vec = 0;
  int n_err = 0;

  assign prog_data = rom[prog_addr];
  assign jmp       = (instruction == 4'hC);
  assign rtn       = (instruction == 4'hD);
  assign flag_o    = (instruction == 4'h0);
  assign flag_f    = (instruction == 4'hF);

  always #5 clk = ~clk;

  mc_sequencer #(.ADDR_W(ADDR_W), .STACK_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .instruction(instruction),
    .io_addr    (io_addr),
    .jmp        (jmp),
    .rtn        (rtn),
    .flag_o     (flag_o),
    .flag_f     (flag_f),
    .rr         (rr),
    .running    (running),
    .halted     (halted),
    .stack_err  (stack_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] w(input logic [3:0] op, input logic [7:0] a);
    return {op, a};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_run();
    run = 1'b1;
    step();
    run = 1'b0;
  endtask

  task automatic fill_rom();
    for (int i = 0; i < 2**ADDR_W; i++) rom[i] = w(4'h1, 8'h00);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic check_issue(input string tag, input int pc, input int op);
    check({tag, ".pc"}, 32'(prog_addr), pc);
    check({tag, ".op"}, 32'(instruction), op);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, ".instr"}, 32'(instruction), 0);
    check({tag, ".io"},    32'(io_addr), 0);
    check({tag, ".pc"},    32'(prog_addr), 0);
    check({tag, ".run"},   32'(running), 0);
    check({tag, ".halt"},  32'(halted), 0);
    check({tag, ".err"},   32'(stack_err), 0);
  endtask

  initial begin
    // Linear program with NOPO wrap
    fill_rom();
    rom[0] = w(4'h1, 8'h11);
    rom[1] = w(4'h3, 8'h12);
    rom[2] = w(4'h8, 8'h13);
    rom[3] = w(4'h0, 8'h00);
    #3;
    check_zero_outputs("rst");
    repeat (2) step();
    rst_n = 1'b1;
    step();
    check("idle.run", 32'(running), 0);
    check("idle.pc", 32'(prog_addr), 0);
    pulse_run();
    check("lin.running", 32'(running), 1);
    check_issue("lin0", 0, 1);
    check("lin0.io", 32'(io_addr), 'h11);
    step();
    check_issue("lin1", 1, 3);
    run = 1'b1;
    step();
    run = 1'b0;
    check_issue("lin2", 2, 8);
    step();
    check_issue("lin3", 3, 0);
    step();
    check_issue("lin_wrap", 0, 1);
    check("lin_wrap.run", 32'(running), 1);

    // Call and return
    do_reset();
    fill_rom();
    rom[5]    = w(4'hC, 8'h10);
    rom[8'h10] = w(4'hD, 8'h00);
    rom[7]    = w(4'hD, 8'h00);
    pulse_run();
    repeat (5) step();
    check_issue("call", 5, 'hC);
    check("call.io", 32'(io_addr), 'h10);
    step();
    check_issue("sub", 'h10, 'hD);
    step();
`ifdef MC_SEQ_CALL_STACK_EN
    check_issue("ret", 5, 'hC);
    step();
    check_issue("ret_skip", 6, 1);
    check("ret.err", 32'(stack_err), 0);
    step();
    check_issue("rtn2", 7, 'hD);
    step();
    check("underflow.pc", 32'(prog_addr), 0);
    check("underflow.err", 32'(stack_err), 1);
`else
    check_issue("ret0", 0, 1);
    step();
    check("ret0_skip.pc", 32'(prog_addr), 1);
    check("ret0.err", 32'(stack_err), 0);
`endif

    // SKZ with rr=0 suppresses the JMP
    do_reset();
    fill_rom();
    rom[2] = w(4'hE, 8'h00);
    rom[3] = w(4'hC, 8'h40);
    rr = 1'b0;
    pulse_run();
    repeat (2) step();
    check_issue("skz", 2, 'hE);
    step();
    check_issue("skz_jmp", 3, 'hC);
    step();
    check("skz_taken.pc", 32'(prog_addr), 4);

    // SKZ with rr=1 lets the JMP through
    do_reset();
    rr = 1'b1;
    pulse_run();
    repeat (3) step();
    check_issue("noskz_jmp", 3, 'hC);
    step();
    check("noskz.pc", 32'(prog_addr), 'h40);
    rr = 1'b0;

    // NOPF halt with simultaneous run, hold, resume
    do_reset();
    fill_rom();
    rom[7] = w(4'hF, 8'h00);
    rom[8] = w(4'h8, 8'h55);
    pulse_run();
    repeat (7) step();
    check_issue("nopf", 7, 'hF);
    run = 1'b1;
    step();
    run = 1'b0;
    check("halt.halted", 32'(halted), 1);
    check("halt.running", 32'(running), 0);
    check("halt.io", 32'(io_addr), 0);
    check_issue("halt", 8, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold.halted", 32'(halted), 1);
      check_issue("hold", 8, 0);
    end
    pulse_run();
    check("resume.running", 32'(running), 1);
    check_issue("resume", 8, 8);
    check("resume.io", 32'(io_addr), 'h55);
    step();
    check("resume_next.pc", 32'(prog_addr), 9);

    // Nested calls beyond a depth-2 stack
    do_reset();
    fill_rom();
    rom[0]     = w(4'hC, 8'h10);
    rom[8'h10] = w(4'hC, 8'h20);
    rom[8'h20] = w(4'hC, 8'h30);
    rom[8'h30] = w(4'hD, 8'h00);
    rom[8'h11] = w(4'hD, 8'h00);
    rom[1]     = w(4'hD, 8'h00);
    pulse_run();
    step();
    check("nest1.pc", 32'(prog_addr), 'h10);
    step();
    check("nest2.pc", 32'(prog_addr), 'h20);
    check("nest2.err", 32'(stack_err), 0);
    step();
    check("nest3.pc", 32'(prog_addr), 'h30);
`ifdef MC_SEQ_CALL_STACK_EN
    check("nest3.err", 32'(stack_err), 1);
    step();
    check("pop1.pc", 32'(prog_addr), 'h10);
    step();
    check("pop1_skip.pc", 32'(prog_addr), 'h11);
    step();
    check("pop2.pc", 32'(prog_addr), 0);
    step();
    check("pop2_skip.pc", 32'(prog_addr), 1);
    step();
    check("empty_pop.pc", 32'(prog_addr), 0);
    check("empty_pop.err", 32'(stack_err), 1);
`else
    check("nest3.err", 32'(stack_err), 0);
    step();
    check("plain_rtn.pc", 32'(prog_addr), 0);
`endif

    // Asynchronous reset in the middle of a call
    do_reset();
    fill_rom();
    rom[0] = w(4'hC, 8'h20);
    pulse_run();
    repeat (3) step();
    check_issue("mid", 'h22, 1);
    check("mid.running", 32'(running), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    step();
    rst_n = 1'b1;
    rom[0] = w(4'hD, 8'h00);
    step();
    check("post_rst.run", 32'(running), 0);
    check("post_rst.pc", 32'(prog_addr), 0);
    pulse_run();
    check_issue("post_rst_rtn", 0, 'hD);
    step();
    check("post_rst_rtn.pc", 32'(prog_addr), 0);
`ifdef MC_SEQ_CALL_STACK_EN
    check("post_rst_rtn.err", 32'(stack_err), 1);
`else
    check("post_rst_rtn.err", 32'(stack_err), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
